// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU fetches and LSU loads/stores, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise LSU has fixed priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,

    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state;
    logic   ownerLsu;
    logic   lastGrantLsu;
    logic   grantLsu;
    logic   accept;

    // On a tie the LSU wins unless round-robin is on and the LSU had the last grant.
    always_comb begin
        grantLsu = lsu_req_valid && (!ifu_req_valid || !RoundRobin || !lastGrantLsu);
    end

    assign accept         = rst && (state == IDLE) && (ifu_req_valid || lsu_req_valid);
    assign ifu_req_ready  = accept && !grantLsu;
    assign lsu_req_ready  = accept && grantLsu;

    assign ifu_resp_valid = rst && (state == WAIT) && mem_resp_valid && !ownerLsu;
    assign lsu_resp_valid = rst && (state == WAIT) && mem_resp_valid && ownerLsu;

    // Read data is passed straight through, but forced to zero while reset is asserted.
    assign ifu_rdata      = rst ? mem_rdata : '0;
    assign lsu_rdata      = rst ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ownerLsu      <= 1'b0;
            lastGrantLsu  <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        ownerLsu      <= grantLsu;
                        lastGrantLsu  <= grantLsu;
                        if (grantLsu) begin
                            mem_addr  <= lsu_addr;
                            mem_wen   <= lsu_wen;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_wmask;
                        end else begin
                            mem_addr  <= ifu_addr;
                            mem_wen   <= 1'b0;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter, checked every cycle against a transaction-level model.
// Expected grant order follows MEM_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MW = DW / 8;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 1'b0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = 64'h1234_5678_9ABC_DEF0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int grants[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction-level model: who owns the port, whether the request has gone out, captured fields.
    bit            mBusy = 1'b0;
    bit            mSent = 1'b0;
    int            mWho = 0;       // 0 = IFU, 1 = LSU
    int            mLastWho = 1;
    logic [AW-1:0] mAddr = '0;
    logic          mWen = 1'b0;
    logic [DW-1:0] mWdata = '0;
    logic [MW-1:0] mWmask = '0;

    function automatic int pickWinner(input bit iv, input bit lv, input int last);
        if (iv && lv) return RR ? (1 - last) : 1;
        return lv ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mBusy = 1'b0; mSent = 1'b0; mWho = 0; mLastWho = 1;
            mAddr = '0; mWen = 1'b0; mWdata = '0; mWmask = '0;
        end else if (!mBusy) begin
            if (ifu_req_valid || lsu_req_valid) begin
                mWho = pickWinner(ifu_req_valid, lsu_req_valid, mLastWho);
                mLastWho = mWho;
                mBusy = 1'b1;
                mSent = 1'b0;
                mAddr  = (mWho == 1) ? lsu_addr : ifu_addr;
                mWen   = (mWho == 1) ? lsu_wen : 1'b0;
                mWdata = (mWho == 1) ? lsu_wdata : '0;
                mWmask = (mWho == 1) ? lsu_wmask : '0;
            end
        end else if (!mSent) begin
            mSent = mem_req_ready;
        end else if (mem_resp_valid) begin
            mBusy = 1'b0;
        end
    end

    always @(negedge clk) begin
        bit anyV;
        int w;
        if (!rst) begin
            check("rst ifu_req_ready", ifu_req_ready, 0);
            check("rst lsu_req_ready", lsu_req_ready, 0);
            check("rst ifu_resp_valid", ifu_resp_valid, 0);
            check("rst lsu_resp_valid", lsu_resp_valid, 0);
            check("rst mem_req_valid", mem_req_valid, 0);
            check("rst mem_addr", mem_addr, 0);
            check("rst mem_wen", mem_wen, 0);
            check("rst mem_wdata", mem_wdata, 0);
            check("rst mem_wmask", mem_wmask, 0);
            check("rst ifu_rdata", ifu_rdata, 0);
            check("rst lsu_rdata", lsu_rdata, 0);
        end else begin
            anyV = ifu_req_valid || lsu_req_valid;
            w = pickWinner(ifu_req_valid, lsu_req_valid, mLastWho);
            check("ifu_req_ready", ifu_req_ready, !mBusy && anyV && (w == 0));
            check("lsu_req_ready", lsu_req_ready, !mBusy && anyV && (w == 1));
            check("mem_req_valid", mem_req_valid, mBusy && !mSent);
            check("mem_addr", mem_addr, mAddr);
            check("mem_wen", mem_wen, mWen);
            check("mem_wdata", mem_wdata, mWdata);
            check("mem_wmask", mem_wmask, mWmask);
            check("ifu_resp_valid", ifu_resp_valid, mBusy && mSent && mem_resp_valid && (mWho == 0));
            check("lsu_resp_valid", lsu_resp_valid, mBusy && mSent && mem_resp_valid && (mWho == 1));
            check("ifu_rdata", ifu_rdata, mem_rdata);
            check("lsu_rdata", lsu_rdata, mem_rdata);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (ifu_req_valid && ifu_req_ready) grants.push_back(0);
            if (lsu_req_valid && lsu_req_ready) grants.push_back(1);
        end
    end

    // Memory responder: optional ready backpressure, response one cycle after the handshake.
    bit            autoMem = 1'b1;
    int            stallLeft = 0;
    bit            hsSeen = 1'b0;
    logic [AW-1:0] hsAddr = '0;

    function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
        return (a == 64'h8000_0000) ? 64'h0000_0000_0010_0073 : (a ^ 64'hA5A5_5A5A_0F0F_F0F0);
    endfunction

    always @(negedge clk) begin
        if (autoMem && rst && mem_req_valid && mem_req_ready) begin
            hsSeen = 1'b1;
            hsAddr = mem_addr;
        end
    end

    always @(posedge clk) begin
        #1;
        if (autoMem) begin
            mem_resp_valid = hsSeen;
            mem_rdata = hsSeen ? memData(hsAddr) : 64'hDEAD_BEEF_0BAD_F00D;
            hsSeen = 1'b0;
            if (mem_req_valid && stallLeft > 0) begin
                mem_req_ready = 1'b0;
                stallLeft--;
            end else begin
                mem_req_ready = mem_req_valid;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit probe(input int k);
        case (k)
            0: return ifu_req_ready;
            1: return lsu_req_ready;
            2: return ifu_resp_valid;
            default: return lsu_resp_valid;
        endcase
    endfunction

    task automatic waitFor(input string name, input int k, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (probe(k)) return;
        end
        check({name, " timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int reqCycles;
        bit gotResp;
        int expGrants[5];

        // Reset with a pending request: nothing may be accepted, all outputs low.
        ifu_req_valid = 1'b1;
        #1;
        check("reset ifu_req_ready literal", ifu_req_ready, 0);
        check("reset ifu_rdata literal", ifu_rdata, 0);
        step(3);
        ifu_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post-reset mem_req_valid literal", mem_req_valid, 0);
        check("post-reset mem_addr literal", mem_addr, 0);
        step(1);

        // Single IFU fetch.
        ifu_addr = 64'h8000_0000;
        ifu_req_valid = 1'b1;
        waitFor("ifu accept", 0, 5);
        t0 = cyc;
        step(1);
        ifu_req_valid = 1'b0;
        waitFor("ifu resp", 2, 10);
        check("ifu resp latency", 64'(cyc - t0), 2);
        check("ifu_rdata literal", ifu_rdata, 64'h0000_0000_0010_0073);
        check("lsu_resp_valid on ifu fetch", lsu_resp_valid, 0);
        step(1);
        @(negedge clk);
        check("ifu_resp_valid pulse width", ifu_resp_valid, 0);
        step(1);

        // LSU write held off by three cycles of backpressure while IFU also waits.
        stallLeft = 3;
        ifu_addr = 64'h8000_0040;
        ifu_req_valid = 1'b1;
        lsu_addr = 64'h8000_1000;
        lsu_wen = 1'b1;
        lsu_wdata = 64'h1122_3344_5566_7788;
        lsu_wmask = 8'h0F;
        lsu_req_valid = 1'b1;
        waitFor("lsu write accept", 1, 5);
        step(1);
        lsu_req_valid = 1'b0;
        reqCycles = 0;
        gotResp = 1'b0;
        for (int i = 0; i < 12 && !gotResp; i++) begin
            @(negedge clk);
            check("ifu_req_ready during lsu write", ifu_req_ready, 0);
            if (mem_req_valid) begin
                reqCycles++;
                check("held mem_addr literal", mem_addr, 64'h8000_1000);
                check("held mem_wen literal", mem_wen, 1);
                check("held mem_wdata literal", mem_wdata, 64'h1122_3344_5566_7788);
                check("held mem_wmask literal", mem_wmask, 8'h0F);
            end
            if (lsu_resp_valid) gotResp = 1'b1;
        end
        check("lsu write ack seen", gotResp, 1);
        check("mem_req_valid held cycles", 64'(reqCycles), 4);
        step(1);
        waitFor("ifu accept after lsu", 0, 5);
        step(1);
        ifu_req_valid = 1'b0;
        lsu_wen = 1'b0;
        waitFor("ifu resp after lsu", 2, 10);
        step(2);

        // Continuous tie from a fresh reset.
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        grants.delete();
        ifu_addr = 64'h8000_0080;
        lsu_addr = 64'h8000_2000;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int i = 0; i < 60 && grants.size() < 4; i++) @(negedge clk);
        check("tie four grants", 64'(grants.size()), 4);
        step(1);
        lsu_req_valid = 1'b0;
        for (int i = 0; i < 30 && grants.size() < 5; i++) @(negedge clk);
        check("tie fifth grant", 64'(grants.size()), 5);
        step(1);
        ifu_req_valid = 1'b0;
        if (RR) expGrants = '{0, 1, 0, 1, 0};
        else    expGrants = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            check($sformatf("grant order %0d", i), 64'((i < grants.size()) ? grants[i] : 9), 64'(expGrants[i]));
        end
        step(6);

        // Reset while waiting for the memory response; the late response must be dropped.
        autoMem = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        ifu_addr = 64'h8000_3000;
        ifu_req_valid = 1'b1;
        waitFor("ifu accept before reset", 0, 5);
        step(1);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step(1);
        mem_req_ready = 1'b0;
        mem_rdata = 64'hCAFE_F00D_CAFE_F00D;
        rst = 1'b0;
        #1;
        check("async reset mem_req_valid", mem_req_valid, 0);
        check("async reset mem_addr", mem_addr, 0);
        check("async reset ifu_rdata", ifu_rdata, 0);
        check("async reset lsu_rdata", lsu_rdata, 0);
        step(1);
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        check("late resp ifu_resp_valid", ifu_resp_valid, 0);
        check("late resp lsu_resp_valid", lsu_resp_valid, 0);

        // Spurious response in IDLE, then a request must still be accepted at once.
        step(1);
        @(negedge clk);
        check("spurious ifu_resp_valid", ifu_resp_valid, 0);
        check("spurious lsu_resp_valid", lsu_resp_valid, 0);
        step(1);
        ifu_addr = 64'h8000_4000;
        ifu_req_valid = 1'b1;
        @(negedge clk);
        check("idle accept after spurious", ifu_req_ready, 1);
        step(1);
        ifu_req_valid = 1'b0;
        mem_resp_valid = 1'b0;
        autoMem = 1'b1;
        waitFor("ifu resp after spurious", 2, 10);
        check("ifu_rdata after spurious", ifu_rdata, 64'h8000_4000 ^ 64'hA5A5_5A5A_0F0F_F0F0);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared memory port between two requesters: instruction fetch (IFU) and load/store unit (LSU).
- Sits between the core and the memory model, replacing the core's direct fetch and store paths.
- Controller FSM allows one outstanding transaction at a time, with valid/ready handshakes on the request, response and memory sides.

Parameters:
- ADDR_WIDTH, 64, address width for all address ports.
- DATA_WIDTH, 64, read/write data width; wmask width is DATA_WIDTH/8.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ifu_req_valid  input  1  IFU read request.
- ifu_req_ready  output  1  IFU request accepted this cycle.
- ifu_addr  input  ADDR_WIDTH  IFU fetch address.
- ifu_resp_valid  output  1  IFU read data valid, one-cycle pulse.
- ifu_rdata  output  DATA_WIDTH  IFU read data.
- lsu_req_valid  input  1  LSU request.
- lsu_req_ready  output  1  LSU request accepted this cycle.
- lsu_addr  input  ADDR_WIDTH  LSU address.
- lsu_wen  input  1  1 = write, 0 = read.
- lsu_wdata  input  DATA_WIDTH  write data.
- lsu_wmask  input  DATA_WIDTH/8  byte write mask.
- lsu_resp_valid  output  1  LSU read data or write acknowledge, one-cycle pulse.
- lsu_rdata  output  DATA_WIDTH  LSU read data.
- mem_req_valid  output  1  request to memory.
- mem_req_ready  input  1  memory accepts request.
- mem_addr, mem_wen, mem_wdata, mem_wmask  output  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  captured request fields.
- mem_resp_valid  input  1  memory response or ack.
- mem_rdata  input  DATA_WIDTH  memory read data.

Behaviour:
- FSM states: IDLE, REQ, WAIT. Registers: state, owner (IFU/LSU), captured addr/wen/wdata/wmask, last_grant.
- Reset (rst=0, asynchronous): state=IDLE, owner=IFU, captured fields=0, last_grant=LSU.
- Outputs during reset: every output 0. Any transaction in flight is dropped and never responded to.
- IDLE:
  - Winner is selected combinationally from the valid requesters.
  - Exactly the winner's req_ready=1 in the same cycle.
  - On accept: capture winner's fields (IFU request: wen=0, wdata=0, wmask=0), set owner, set last_grant, next state REQ.
- REQ:
  - mem_req_valid=1; mem_* outputs are driven from the captured registers and held stable until mem_req_ready.
  - On mem_req_ready=1, go to WAIT.
- WAIT:
  - On mem_resp_valid=1, the owner's resp_valid=1 for that cycle only (combinational from mem_resp_valid); go to IDLE.
  - Writes also wait for mem_resp_valid as their acknowledge.
- ifu_rdata and lsu_rdata both equal mem_rdata at all times; they are meaningful only when the matching resp_valid=1.
- req_ready is 0 for both requesters outside IDLE.
- mem_resp_valid in IDLE or REQ is ignored; no resp_valid is produced.
- Latency: accept at cycle N, mem request at N+1, earliest response N+2, next accept N+3.
- Requester rule: valid and fields are held until ready. The arbiter does not check this rule.
- Default tie-break (macro absent): LSU wins whenever both requesters are valid.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on a tie, the requester not equal to last_grant wins. After reset the first tie goes to IFU.
- Defined: a lone requester always wins immediately.
- Undefined: fixed LSU priority; last_grant is still updated but unused.

Test Plan:
- Single IFU fetch:
  - Stimulus: ifu_addr=0x80000000; mem_req_ready=1; mem_resp_valid the next cycle with mem_rdata=0x00100073.
  - Response: ifu_resp_valid pulses exactly 1 cycle with ifu_rdata=0x00100073, two cycles after accept; lsu_resp_valid stays 0.
- LSU write with backpressure:
  - Stimulus: lsu_wen=1, lsu_addr=0x80001000, wdata=0x1122334455667788, wmask=0x0F; mem_req_ready held low 3 cycles.
  - Response: mem_req_valid=1 and all mem_* fields stable for 4 cycles; lsu_resp_valid pulses on ack; ifu_req_ready=0 throughout.
- Continuous tie, macro undefined:
  - Stimulus: both requesters valid continuously.
  - Response: LSU is granted repeatedly; IFU is granted only once LSU deasserts valid.
- Continuous tie, MEM_ARB_ROUND_ROBIN_EN defined:
  - Stimulus: both requesters valid continuously for 4 transactions.
  - Response: grant order IFU, LSU, IFU, LSU.
- Reset mid-operation:
  - Stimulus: rst=0 while in WAIT, then rst=1; a late mem_resp_valid arrives afterwards.
  - Response: all outputs 0 immediately, FSM back in IDLE; the late mem_resp_valid produces no resp_valid.
- Spurious memory response:
  - Stimulus: mem_resp_valid=1 while in IDLE with no requests.
  - Response: both resp_valid signals stay 0 and the state stays IDLE.
